alu_op_scheduler: RTL and testbench

//  Sequences one arithmetic command (opcode, rs1, rs2) through the shared multi-cycle ALU.

---
 rtl/alu_op_scheduler_pkg.sv | 28 ++
 rtl/alu_op_scheduler_if.sv | 40 ++++
 rtl/alu_op_scheduler_result_serializer.sv | 44 ++++
 rtl/bsg_counter_up_down.sv | 28 ++
 rtl/alu_op_scheduler.sv | 134 +++++++++++++
 tb/tb_alu_op_scheduler.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and constants for the ALU op scheduler.
//  - Opcode constants for the three commands the ALU understands.
//  - sched_state_t: scheduler FSM states. The encoding is visible on state_o.
//  - ALU_RES_W: width of the ALU result bus.
//  - cmd_is_err(): returns 1 for commands that must never reach the ALU.
package alu_op_scheduler_pkg;

    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_MUL    = 8'h02;
    localparam logic [7:0] OP_DIV    = 8'h03;
    localparam int         ALU_RES_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        ERR   = 3'd4
    } sched_state_t;

    // Unknown opcodes and divide-by-zero are rejected before the ALU is launched.
    function automatic logic cmd_is_err(input logic [7:0] op, input logic [31:0] rs2);
        logic known;
        known = (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
        return !known || ((op == OP_DIV) && (rs2 == 32'd0));
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Bundle of the scheduler's bus signals: the command side (from the parser),
// the ALU side, the TX byte stream, and the debug/error outputs.
//  slave  : the scheduler's view.
//  master : the view of the environment around it (parser, ALU, TX).
interface alu_op_scheduler_if;
    import alu_op_scheduler_pkg::*;

    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [7:0]           cmd_opcode_i;
    logic [31:0]          cmd_rs1_i;
    logic [31:0]          cmd_rs2_i;
    logic [7:0]           alu_opcode_o;
    logic [31:0]          alu_data1_o;
    logic [31:0]          alu_data2_o;
    logic                 alu_start_o;
    logic                 alu_busy_i;
    logic                 alu_valid_i;
    logic [ALU_RES_W-1:0] alu_result_i;
    logic [7:0]           data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 err_o;
    logic [2:0]           state_o;

    modport slave (
        input  cmd_valid_i, cmd_opcode_i, cmd_rs1_i, cmd_rs2_i,
        input  alu_busy_i, alu_valid_i, alu_result_i, ready_i,
        output cmd_ready_o, alu_opcode_o, alu_data1_o, alu_data2_o, alu_start_o,
        output data_o, valid_o, err_o, state_o
    );

    modport master (
        output cmd_valid_i, cmd_opcode_i, cmd_rs1_i, cmd_rs2_i,
        output alu_busy_i, alu_valid_i, alu_result_i, ready_i,
        input  cmd_ready_o, alu_opcode_o, alu_data1_o, alu_data2_o, alu_start_o,
        input  data_o, valid_o, err_o, state_o
    );

endinterface

// File: rtl/alu_op_scheduler_result_serializer.sv
// Shift an ALU result out as a byte stream, LSB first.
//  clk, rst  : clock / synchronous active-high reset
//  load_i    : capture data_i and nbytes_i (overrides any shifting)
//  nbytes_i  : number of bytes to emit (1..8)
//  data_i    : 64-bit result
//  valid_o   : a byte is on data_o
//  ready_i   : downstream accepts data_o this cycle
//  data_o    : current byte
//  done_o    : last byte is being accepted this cycle
module alu_op_scheduler_result_serializer
    import alu_op_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [3:0]           nbytes_i,
    input  logic [ALU_RES_W-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [7:0]           data_o,
    output logic                 done_o
);

    logic [ALU_RES_W-1:0] shreg;
    logic [3:0]           cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load_i) begin
            shreg <= data_i;
            cnt   <= nbytes_i;
        end else if (valid_o && ready_i) begin
            shreg <= {8'h00, shreg[ALU_RES_W-1:8]};
            cnt   <= cnt - 4'd1;
        end
    end

    assign valid_o = (cnt != 4'd0);
    assign data_o  = shreg[7:0];
    assign done_o  = valid_o && ready_i && (cnt == 4'd1);

endmodule

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter.
//  clk_i    : clock, rising edge
//  reset_i  : synchronous reset to init_val_p
//  up_i     : amount to add this cycle
//  down_i   : amount to subtract this cycle
//  count_o  : current count
module bsg_counter_up_down #(
    parameter int max_val_p  = 15,
    parameter int init_val_p = 0,
    parameter int max_step_p = 1,
    localparam int step_w_lp = $clog2(max_step_p + 1),
    localparam int cnt_w_lp  = $clog2(max_val_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [step_w_lp-1:0] up_i,
    input  logic [step_w_lp-1:0] down_i,
    output logic [cnt_w_lp-1:0]  count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_o <= cnt_w_lp'(init_val_p);
        else
            count_o <= count_o + cnt_w_lp'(up_i) - cnt_w_lp'(down_i);
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Runs one arithmetic command through the shared multi-cycle ALU and streams
// the result bytes (LSB first) to the TX path. Bad commands and ALU timeouts
// produce a single ERR_BYTE_P instead.
//  clk, rst : clock / synchronous active-high reset
//  bus      : slave side of alu_op_scheduler_if
//             cmd_*  : command handshake from the packet parser
//             alu_*  : launch/result handshake with the ALU
//             data_o/valid_o/ready_i : byte stream to TX
//             err_o  : one-cycle pulse when ERR is entered
//             state_o: encoded FSM state for debug
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int         TIMEOUT_P   = 1024,
    parameter logic [7:0] ERR_BYTE_P  = 8'hEE,
    parameter int         MUL_BYTES_P = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_scheduler_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT_P);

    sched_state_t state, state_nxt;

    logic             accept;
    logic             alu_start;
    logic             ser_load;
    logic             ser_valid;
    logic             ser_done;
    logic [7:0]       ser_data;
    logic [3:0]       ser_nbytes;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             err_q;
    logic [7:0]       op_q;
    logic [31:0]      rs1_q, rs2_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        alu_start = 1'b0;
        ser_load  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = cmd_is_err(bus.cmd_opcode_i, bus.cmd_rs2_i) ? ERR : START;
                end
            end
            START: begin
                if (!bus.alu_busy_i) begin
                    alu_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (bus.alu_valid_i) begin
                    ser_load  = 1'b1;
                    state_nxt = SEND;
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                end
            end
            SEND:    if (ser_done)    state_nxt = IDLE;
            ERR:     if (bus.ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch: feeds the ALU and holds until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= bus.cmd_opcode_i;
            rs1_q <= bus.cmd_rs1_i;
            rs2_q <= bus.cmd_rs2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (state_nxt == ERR) && (state != ERR);
    end

    // Held in reset outside WAIT, so it reads 0 on the first WAIT cycle.
    bsg_counter_up_down #(
        .max_val_p  (TIMEOUT_P - 1),
        .init_val_p (0),
        .max_step_p (1)
    ) u_tmo_cnt (
        .clk_i   (clk),
        .reset_i (rst || (state != WAIT)),
        .up_i    (state == WAIT),
        .down_i  (1'b0),
        .count_o (tmo_cnt)
    );

    assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_P - 1));
    assign ser_nbytes = (op_q == OP_MUL) ? 4'(MUL_BYTES_P) : 4'd4;

    alu_op_scheduler_result_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ser_load),
        .nbytes_i (ser_nbytes),
        .data_i   (bus.alu_result_i),
        .valid_o  (ser_valid),
        .ready_i  (bus.ready_i && (state == SEND)),
        .data_o   (ser_data),
        .done_o   (ser_done)
    );

    assign bus.cmd_ready_o  = (state == IDLE);
    assign bus.alu_opcode_o = op_q;
    assign bus.alu_data1_o  = rs1_q;
    assign bus.alu_data2_o  = rs2_q;
    assign bus.alu_start_o  = alu_start;
    assign bus.valid_o      = (state == ERR) || ((state == SEND) && ser_valid);
    assign bus.data_o       = (state == ERR) ? ERR_BYTE_P : ser_data;
    assign bus.err_o        = err_q;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a byte scoreboard.
module tb_alu_op_scheduler;
    import alu_op_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;
    logic [7:0] exp_q[$];

    alu_op_scheduler_if ifc();

    alu_op_scheduler #(.TIMEOUT_P(16), .ERR_BYTE_P(8'hEE), .MUL_BYTES_P(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && ifc.alu_start_o) start_cnt <= start_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return {32'd0, a + b};
            OP_MUL:  return 64'(a) * 64'(b);
            default: return {32'd0, a / b};
        endcase
    endfunction

    task automatic push_res(input logic [63:0] r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(r[i*8 +: 8]);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        ifc.cmd_valid_i  = 1'b1;
        ifc.cmd_opcode_i = op;
        ifc.cmd_rs1_i    = a;
        ifc.cmd_rs2_i    = b;
        @(negedge clk);
        chk("cmd_ready_idle", ifc.cmd_ready_o, 1);
        @(posedge clk); #1;
        ifc.cmd_valid_i = 1'b0;
    endtask

    task automatic expect_start();
        @(negedge clk);
        chk("alu_start", ifc.alu_start_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic alu_reply(input int delay, input logic [63:0] r);
        repeat (delay) begin @(posedge clk); #1; end
        ifc.alu_valid_i  = 1'b1;
        ifc.alu_result_i = r;
        @(posedge clk); #1;
        ifc.alu_valid_i = 1'b0;
    endtask

    task automatic drain(input int n, input bit stall);
        int got = 0;
        int cyc = 0;
        bit hold = 0;
        logic [7:0] held = '0;
        logic [7:0] e;
        while (got < n && cyc < 100) begin
            ifc.ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (hold) chk("stall_stable", {ifc.valid_o, ifc.data_o}, {1'b1, held});
            if (!stall) chk("valid_each_cycle", ifc.valid_o, 1);
            hold = 0;
            if (ifc.valid_o) begin
                if (ifc.ready_i) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    chk("byte", ifc.data_o, e);
                    got++;
                end else begin
                    hold = 1;
                    held = ifc.data_o;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        ifc.ready_i = 1'b0;
        chk("drain_count", got, n);
    endtask

    initial begin
        int n;
        int s0;
        logic [63:0] r;
        ifc.cmd_valid_i  = 1'b0;
        ifc.cmd_opcode_i = '0;
        ifc.cmd_rs1_i    = '0;
        ifc.cmd_rs2_i    = '0;
        ifc.alu_busy_i   = 1'b0;
        ifc.alu_valid_i  = 1'b0;
        ifc.alu_result_i = '0;
        ifc.ready_i      = 1'b0;

        // Reset state
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_cmd_ready", ifc.cmd_ready_o, 1);
        chk("rst_state", ifc.state_o, 0);
        chk("rst_outs", {ifc.valid_o, ifc.err_o, ifc.alu_start_o, ifc.data_o}, 0);
        chk("rst_alu_data", {ifc.alu_opcode_o, ifc.alu_data1_o, ifc.alu_data2_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD 5+7, 3-cycle ALU, consecutive bytes
        s0 = start_cnt;
        send_cmd(OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("add_start", ifc.alu_start_o, 1);
        chk("add_latch", {ifc.alu_opcode_o, ifc.alu_data1_o, ifc.alu_data2_o}, {OP_ADD, 32'd5, 32'd7});
        chk("add_busy_ready", ifc.cmd_ready_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("start_one_cycle", ifc.alu_start_o, 0);
        chk("wait_state", ifc.state_o, 2);
        push_res(model(OP_ADD, 32'd5, 32'd7), 4);
        alu_reply(2, model(OP_ADD, 32'd5, 32'd7));
        drain(4, 0);
        @(negedge clk);
        chk("add_back_idle", {ifc.cmd_ready_o, ifc.valid_o}, 2'b10);
        chk("add_one_start", start_cnt - s0, 1);
        @(posedge clk); #1;

        // MUL with random TX stalls
        send_cmd(OP_MUL, 32'h10000, 32'h10000);
        expect_start();
        r = model(OP_MUL, 32'h10000, 32'h10000);
        push_res(r, 8);
        alu_reply(1, r);
        drain(8, 1);

        // DIV by zero: no ALU launch, single EE
        s0 = start_cnt;
        send_cmd(OP_DIV, 32'd9, 32'd0);
        @(negedge clk);
        chk("div0_err_pulse", ifc.err_o, 1);
        chk("div0_state", ifc.state_o, 4);
        chk("div0_byte", {ifc.valid_o, ifc.data_o}, {1'b1, 8'hEE});
        @(posedge clk); #1;
        @(negedge clk);
        chk("div0_err_once", ifc.err_o, 0);
        chk("div0_hold", {ifc.valid_o, ifc.data_o}, {1'b1, 8'hEE});
        @(posedge clk); #1;
        exp_q.push_back(8'hEE);
        drain(1, 0);
        @(negedge clk);
        chk("div0_idle", ifc.state_o, 0);
        chk("div0_no_start", start_cnt - s0, 0);
        @(posedge clk); #1;

        // Unknown opcode
        send_cmd(8'h55, 32'd1, 32'd2);
        @(negedge clk);
        chk("badop_err", {ifc.err_o, ifc.state_o}, {1'b1, 3'd4});
        @(posedge clk); #1;
        exp_q.push_back(8'hEE);
        drain(1, 0);

        // Timeout: exactly 16 WAIT cycles then ERR
        send_cmd(OP_ADD, 32'd1, 32'd2);
        expect_start();
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (ifc.state_o != 3'd2) break;
            n++;
            @(posedge clk); #1;
        end
        chk("tmo_wait_cycles", n, 16);
        chk("tmo_err", {ifc.err_o, ifc.state_o, ifc.data_o}, {1'b1, 3'd4, 8'hEE});
        @(posedge clk); #1;
        exp_q.push_back(8'hEE);
        drain(1, 0);

        // Result on the timeout cycle wins
        send_cmd(OP_ADD, 32'd1, 32'd2);
        expect_start();
        repeat (15) begin @(posedge clk); #1; end
        r = 64'h1234_5678_9ABC_DEF0;
        ifc.alu_valid_i  = 1'b1;
        ifc.alu_result_i = r;
        @(negedge clk);
        chk("tmo_edge_wait", ifc.state_o, 2);
        @(posedge clk); #1;
        ifc.alu_valid_i = 1'b0;
        push_res(r, 4);
        @(negedge clk);
        chk("tmo_edge_no_err", {ifc.err_o, ifc.state_o}, {1'b0, 3'd3});
        @(posedge clk); #1;
        drain(4, 0);

        // ALU busy holds off start
        s0 = start_cnt;
        ifc.alu_busy_i = 1'b1;
        send_cmd(OP_ADD, 32'd3, 32'd4);
        repeat (5) begin
            @(negedge clk);
            chk("busy_no_start", {ifc.alu_start_o, ifc.state_o}, {1'b0, 3'd1});
            @(posedge clk); #1;
        end
        ifc.alu_busy_i = 1'b0;
        expect_start();
        @(negedge clk);
        chk("busy_pulse_end", {ifc.alu_start_o, ifc.state_o}, {1'b0, 3'd2});
        push_res(model(OP_ADD, 32'd3, 32'd4), 4);
        alu_reply(1, model(OP_ADD, 32'd3, 32'd4));
        drain(4, 0);
        chk("busy_one_start", start_cnt - s0, 1);

        // Reset mid-SEND, late alu_valid ignored, then ADD 1+1
        send_cmd(OP_ADD, 32'd10, 32'd20);
        expect_start();
        push_res(model(OP_ADD, 32'd10, 32'd20), 4);
        alu_reply(1, model(OP_ADD, 32'd10, 32'd20));
        drain(2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_send_outs", {ifc.valid_o, ifc.cmd_ready_o, ifc.state_o}, {1'b0, 1'b1, 3'd0});
        @(posedge clk); #1;
        ifc.alu_valid_i  = 1'b1;
        ifc.alu_result_i = 64'hAB;
        @(posedge clk); #1;
        ifc.alu_valid_i = 1'b0;
        @(negedge clk);
        chk("late_valid_ignored", {ifc.valid_o, ifc.state_o}, {1'b0, 3'd0});
        @(posedge clk); #1;
        send_cmd(OP_ADD, 32'd1, 32'd1);
        expect_start();
        push_res(model(OP_ADD, 32'd1, 32'd1), 4);
        alu_reply(0, model(OP_ADD, 32'd1, 32'd1));
        drain(4, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
